// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
//   Packet sequencer between the UART byte streams and the shared ALU units.
//   Parses framed packets (opcode, reserved, len_lo, len_hi, payload; len counts
//   the 4 header bytes), gathers little-endian 32-bit operands, sums ADD locally,
//   hands MUL/DIV steps to the external multiplier/divider over valid/ready and
//   serialises the result LSB first on the TX stream. ECHO payload is looped back.
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   rx_data_i/rx_valid_i/rx_ready_o   incoming byte stream
//   tx_data_o/tx_valid_o/tx_ready_i   outgoing byte stream
//   mul_a_o/mul_b_o/mul_valid_o/mul_ready_i, mul_res_i/mul_res_v_i
//                                     multiplier request and result
//   div_a_o/div_b_o/div_valid_o/div_ready_i, div_quot_i/div_rem_i/div_res_v_i
//                                     divider request and result
//   busy_o                            low only while waiting for an opcode
//   err_o                             1-cycle pulse after a malformed packet is drained
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_OPC     | idle, waiting for opcode byte
// S_RSVD    | waiting for reserved header byte
// S_LEN_LO  | waiting for low length byte
// S_LEN_HI  | waiting for high length byte, header checked here
// S_PAYLOAD | collecting operand bytes, or looping ECHO bytes to tx
// S_ISSUE   | presenting acc/op to multiplier or divider
// S_WAIT    | waiting for the unit's result pulse
// S_SEND    | transmitting the result bytes
// S_DRAIN   | discarding payload of a malformed packet, then err_o
module uart_alu_ctrl #(
  parameter logic [7:0]  OPC_ECHO = 8'hEC,
  parameter logic [7:0]  OPC_ADD  = 8'hAD,
  parameter logic [7:0]  OPC_MUL  = 8'h88,
  parameter logic [7:0]  OPC_DIV  = 8'hD1,
  parameter logic [15:0] MAX_LEN  = 16'd1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_valid_o,
  input  logic        mul_ready_i,
  input  logic [31:0] mul_res_i,
  input  logic        mul_res_v_i,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_valid_o,
  input  logic        div_ready_i,
  input  logic [31:0] div_quot_i,
  input  logic [31:0] div_rem_i,
  input  logic        div_res_v_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [3:0] {
    S_OPC, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_ISSUE, S_WAIT, S_SEND, S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [7:0]  opc_q;
  logic [7:0]  len_lo_q;
  logic [15:0] cnt_q;        // payload bytes still to be received
  logic [1:0]  byte_idx_q;   // byte position inside the current operand
  logic        first_q;      // next completed operand is the first one
  logic [31:0] op_q;
  logic [31:0] acc_q;
  logic [31:0] rem_q;
  logic [7:0]  echo_data_q;
  logic        echo_valid_q;
  logic [2:0]  send_idx_q;

  logic        is_echo, is_add, is_mul, is_div;
  logic [15:0] len_full;
  logic [31:0] op_full;
  logic [63:0] result;
  logic        hdr_ok;
  logic        last_send;
  logic        tx_fire;

  assign is_echo  = (opc_q == OPC_ECHO);
  assign is_add   = (opc_q == OPC_ADD);
  assign is_mul   = (opc_q == OPC_MUL);
  assign is_div   = (opc_q == OPC_DIV);
  assign len_full = {rx_data_i, len_lo_q};
  // the 4th operand byte completes the word straight from the rx bus
  assign op_full  = {rx_data_i, op_q[23:0]};
  assign result   = {rem_q, acc_q};
  assign last_send = (send_idx_q == (is_div ? 3'd7 : 3'd3));

  always_comb begin
    hdr_ok = 1'b0;
    if (len_full >= 16'd4 && len_full <= MAX_LEN) begin
      if (is_echo)
        hdr_ok = 1'b1;
      else if (is_add || is_mul)
        hdr_ok = (len_full >= 16'd12) && (len_full[1:0] == 2'b00);
      else if (is_div)
        hdr_ok = (len_full == 16'd12);
    end
  end

  assign tx_valid_o = (state == S_SEND) || echo_valid_q;
  assign tx_fire    = tx_valid_o && tx_ready_i;
  assign busy_o     = (state != S_OPC);

  always_comb begin
    tx_data_o = 8'h00;
    if (state == S_SEND)
      tx_data_o = result[{send_idx_q, 3'b000} +: 8];
    else if (echo_valid_q)
      tx_data_o = echo_data_q;
  end

  // operand buses are only driven while a request is outstanding
  assign mul_a_o = (state == S_ISSUE && is_mul) ? acc_q : 32'h0;
  assign mul_b_o = (state == S_ISSUE && is_mul) ? op_q  : 32'h0;
  assign div_a_o = (state == S_ISSUE && is_div) ? acc_q : 32'h0;
  assign div_b_o = (state == S_ISSUE && is_div) ? op_q  : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= S_OPC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rx_ready_o  = 1'b0;
    mul_valid_o = 1'b0;
    div_valid_o = 1'b0;
    err_o       = 1'b0;
    case (state)
      S_OPC: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) state_nxt = S_RSVD;
      end
      S_RSVD: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          if (!hdr_ok)
            state_nxt = S_DRAIN;
          else if (len_full == 16'd4)
            state_nxt = S_OPC;   // only an empty ECHO can get here
          else
            state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (is_echo) begin
          rx_ready_o = !echo_valid_q;
          if (tx_fire && cnt_q == 16'd0) state_nxt = S_OPC;
        end else begin
          rx_ready_o = 1'b1;
          if (rx_valid_i && byte_idx_q == 2'd3) begin
            if (!first_q && !is_add)
              state_nxt = S_ISSUE;
            else if (cnt_q == 16'd1)
              state_nxt = S_SEND;
          end
        end
      end
      S_ISSUE: begin
        mul_valid_o = is_mul;
        div_valid_o = is_div;
        if ((is_mul && mul_ready_i) || (is_div && div_ready_i)) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (is_mul && mul_res_v_i)
          state_nxt = (cnt_q == 16'd0) ? S_SEND : S_PAYLOAD;
        else if (is_div && div_res_v_i)
          state_nxt = S_SEND;
      end
      S_SEND: begin
        if (tx_ready_i && last_send) state_nxt = S_OPC;
      end
      S_DRAIN: begin
        if (cnt_q == 16'd0) begin
          err_o     = 1'b1;
          state_nxt = S_OPC;
        end else begin
          rx_ready_o = 1'b1;
        end
      end
      default: state_nxt = S_OPC;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opc_q        <= 8'h00;
      len_lo_q     <= 8'h00;
      cnt_q        <= 16'h0000;
      byte_idx_q   <= 2'd0;
      first_q      <= 1'b0;
      op_q         <= 32'h0;
      acc_q        <= 32'h0;
      rem_q        <= 32'h0;
      echo_data_q  <= 8'h00;
      echo_valid_q <= 1'b0;
      send_idx_q   <= 3'd0;
    end else begin
      case (state)
        S_OPC: begin
          if (rx_valid_i) opc_q <= rx_data_i;
        end
        S_LEN_LO: begin
          if (rx_valid_i) len_lo_q <= rx_data_i;
        end
        S_LEN_HI: begin
          if (rx_valid_i) begin
            // short headers drain nothing and report straight away
            cnt_q      <= (len_full >= 16'd4) ? (len_full - 16'd4) : 16'd0;
            byte_idx_q <= 2'd0;
            first_q    <= 1'b1;
            op_q       <= 32'h0;
            acc_q      <= 32'h0;
            rem_q      <= 32'h0;
            send_idx_q <= 3'd0;
          end
        end
        S_PAYLOAD: begin
          if (is_echo) begin
            if (rx_valid_i && !echo_valid_q) begin
              echo_data_q  <= rx_data_i;
              echo_valid_q <= 1'b1;
              cnt_q        <= cnt_q - 16'd1;
            end else if (tx_fire) begin
              echo_valid_q <= 1'b0;
            end
          end else if (rx_valid_i) begin
            cnt_q      <= cnt_q - 16'd1;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q != 2'd3) begin
              op_q[{byte_idx_q, 3'b000} +: 8] <= rx_data_i;
            end else begin
              op_q    <= op_full;
              first_q <= 1'b0;
              if (first_q)
                acc_q <= op_full;
              else if (is_add)
                acc_q <= acc_q + op_full;
            end
          end
        end
        S_WAIT: begin
          if (is_mul && mul_res_v_i) begin
            acc_q <= mul_res_i;
          end else if (is_div && div_res_v_i) begin
            acc_q <= div_quot_i;
            rem_q <= div_rem_i;
          end
        end
        S_SEND: begin
          if (tx_ready_i) send_idx_q <= last_send ? 3'd0 : send_idx_q + 3'd1;
        end
        S_DRAIN: begin
          if (rx_valid_i && cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl
//   Self-checking bench for uart_alu_ctrl. Packets are built as byte queues,
//   a packet-level reference model derives the expected tx bytes, err pulses
//   and unit handshake counts, and behavioural multiplier/divider responders
//   with random ready and latency sit on the ALU ports.
`timescale 1ns/1ps
module tb_uart_alu_ctrl;
  localparam logic [7:0] ECHO = 8'hEC, ADD = 8'hAD, MUL = 8'h88, DIV = 8'hD1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] mul_a_o, mul_b_o, mul_res_i;
  logic        mul_valid_o, mul_ready_i, mul_res_v_i;
  logic [31:0] div_a_o, div_b_o, div_quot_i, div_rem_i;
  logic        div_valid_o, div_ready_i, div_res_v_i;
  logic        busy_o, err_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int exp_err, exp_mul, exp_div;
  int err_seen, mul_hs, div_hs;
  bit stall = 1'b0;
  bit stray_en = 1'b0;

  bit          mul_pend, div_pend;
  int          mul_dly, div_dly;
  logic [31:0] mul_prod, div_q, div_r;
  bit          hold_v;
  logic [7:0]  hold_d;

  always #5 clk_i = ~clk_i;

  uart_alu_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_valid_o(mul_valid_o),
    .mul_ready_i(mul_ready_i), .mul_res_i(mul_res_i), .mul_res_v_i(mul_res_v_i),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_valid_o(div_valid_o),
    .div_ready_i(div_ready_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
    .div_res_v_i(div_res_v_i), .busy_o(busy_o), .err_o(err_o)
  );

  // Responders and tx sink, all acting on the falling edge.
  initial begin
    tx_ready_i = 1'b0; mul_ready_i = 1'b0; mul_res_i = '0; mul_res_v_i = 1'b0;
    div_ready_i = 1'b0; div_quot_i = '0; div_rem_i = '0; div_res_v_i = 1'b0;
    mul_pend = 0; div_pend = 0; hold_v = 0; mul_dly = 0; div_dly = 0;
    forever begin
      @(negedge clk_i);
      if (hold_v && !rst_i) begin
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== hold_d) begin
          errors++;
          $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid_o, tx_data_o, hold_d);
        end
      end
      if (err_o === 1'b1) err_seen++;
      if (rst_i) begin mul_pend = 0; div_pend = 0; end

      mul_res_v_i = 1'b0;
      if (mul_pend) begin
        if (mul_dly == 0) begin mul_res_v_i = 1'b1; mul_res_i = mul_prod; mul_pend = 0; end
        else mul_dly--;
      end else if (stray_en && ($urandom % 6) == 0) begin
        mul_res_v_i = 1'b1; mul_res_i = $urandom;
      end
      div_res_v_i = 1'b0;
      if (div_pend) begin
        if (div_dly == 0) begin
          div_res_v_i = 1'b1; div_quot_i = div_q; div_rem_i = div_r; div_pend = 0;
        end else div_dly--;
      end else if (stray_en && ($urandom % 6) == 0) begin
        div_res_v_i = 1'b1; div_quot_i = $urandom; div_rem_i = $urandom;
      end

      mul_ready_i = (($urandom % 3) != 0);
      if (mul_valid_o === 1'b1 && mul_ready_i) begin
        mul_hs++; mul_pend = 1; mul_dly = int'($urandom % 4);
        mul_prod = mul_a_o * mul_b_o;
      end
      div_ready_i = (($urandom % 3) != 0);
      if (div_valid_o === 1'b1 && div_ready_i) begin
        div_hs++; div_pend = 1; div_dly = int'($urandom % 4);
        if (div_b_o == 32'h0) begin
          div_q = 32'hFFFF_FFFF; div_r = div_a_o;
        end else begin
          div_q = $signed(div_a_o) / $signed(div_b_o);
          div_r = $signed(div_a_o) % $signed(div_b_o);
        end
      end

      tx_ready_i = stall ? 1'b0 : (($urandom % 4) != 0);
      if (tx_valid_o === 1'b1 && tx_ready_i) got_q.push_back(tx_data_o);
      hold_v = (tx_valid_o === 1'b1) && !tx_ready_i && !rst_i;
      hold_d = tx_data_o;
    end
  end

  // Reference model: walks every packet in pkt_q and states what must come out.
  task automatic model();
    int i, len, n, nops;
    logic [7:0] opc;
    bit ok;
    logic [31:0] ops[$];
    logic [31:0] r;
    int sa, sb, q, rm;
    exp_q.delete(); exp_err = 0; exp_mul = 0; exp_div = 0;
    i = 0;
    while (i + 4 <= pkt_q.size()) begin
      opc = pkt_q[i];
      len = int'({pkt_q[i+3], pkt_q[i+2]});
      n   = (len >= 4) ? len - 4 : 0;
      ok  = (len >= 4) && (len <= 1024) &&
            ((opc == ECHO) ||
             ((opc == ADD || opc == MUL) && len >= 12 && (len % 4) == 0) ||
             (opc == DIV && len == 12));
      if (!ok) begin
        exp_err++;
      end else if (opc == ECHO) begin
        for (int k = 0; k < n; k++) exp_q.push_back(pkt_q[i+4+k]);
      end else begin
        ops.delete();
        nops = n / 4;
        for (int k = 0; k < nops; k++)
          ops.push_back({pkt_q[i+7+4*k], pkt_q[i+6+4*k], pkt_q[i+5+4*k], pkt_q[i+4+4*k]});
        if (opc == DIV) begin
          exp_div++;
          sa = int'(ops[0]); sb = int'(ops[1]);
          if (sb == 0) begin q = -1; rm = sa; end
          else begin q = sa / sb; rm = sa - q * sb; end
          for (int k = 0; k < 4; k++) exp_q.push_back(8'(q >> (8 * k)));
          for (int k = 0; k < 4; k++) exp_q.push_back(8'(rm >> (8 * k)));
        end else begin
          r = ops[0];
          for (int k = 1; k < nops; k++) r = (opc == ADD) ? r + ops[k] : r * ops[k];
          if (opc == MUL) exp_mul += nops - 1;
          for (int k = 0; k < 4; k++) exp_q.push_back(8'(r >> (8 * k)));
        end
      end
      i += 4 + n;
    end
  endtask

  task automatic put_hdr(input logic [7:0] opc, input int len);
    pkt_q.push_back(opc); pkt_q.push_back(8'($urandom));
    pkt_q.push_back(len[7:0]); pkt_q.push_back(len[15:8]);
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) pkt_q.push_back(w[8*k +: 8]);
  endtask

  task automatic pkt_arith(input logic [7:0] opc, input int n,
                           input logic [31:0] a, b, c, d);
    logic [31:0] w[4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    put_hdr(opc, 4 + 4 * n);
    for (int k = 0; k < n; k++) put_word(w[k]);
  endtask

  task automatic pkt_raw(input logic [7:0] opc, input int len);
    put_hdr(opc, len);
    for (int k = 0; k < len - 4; k++) pkt_q.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (($urandom % 4) == 0) @(negedge clk_i);
    rx_data_i = b; rx_valid_i = 1'b1; t = 0;
    while (rx_ready_o !== 1'b1 && t < 5000) begin @(negedge clk_i); t++; end
    if (t >= 5000) begin
      checks++; errors++;
      $display("FAIL rx_accept: rx_ready stayed %b, required 1", rx_ready_o);
    end
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic start_pkt();
    model();
    got_q.delete(); err_seen = 0; mul_hs = 0; div_hs = 0;
  endtask

  task automatic send_all();
    for (int k = 0; k < pkt_q.size(); k++) send_byte(pkt_q[k]);
  endtask

  task automatic finish_pkt(input string name);
    int t, nb;
    t = 0;
    while (t < 20000 && !(busy_o === 1'b0 && got_q.size() >= exp_q.size())) begin
      @(negedge clk_i); t++;
    end
    checks++;
    if (t >= 20000) begin
      errors++;
      $display("FAIL %s done: busy=%b tx_bytes=%0d, required idle with %0d bytes", name, busy_o, got_q.size(), exp_q.size());
    end
    repeat (4) @(negedge clk_i);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s tx_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    end
    nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < nb; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s tx_byte[%0d]: got %h, required %h", name, k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("FAIL %s err_pulses: got %0d, required %0d", name, err_seen, exp_err);
    end
    checks++;
    if (mul_hs !== exp_mul || div_hs !== exp_div) begin
      errors++;
      $display("FAIL %s handshakes: mul %0d div %0d, required mul %0d div %0d", name, mul_hs, div_hs, exp_mul, exp_div);
    end
    pkt_q.delete();
  endtask

  task automatic run_packet(input string name);
    start_pkt(); send_all(); finish_pkt(name);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({tx_valid_o, tx_data_o, mul_valid_o, mul_a_o, mul_b_o, div_valid_o,
         div_a_o, div_b_o, busy_o, err_o} !== '0 || rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s outputs: rx_rdy=%b tx_v=%b tx_d=%h mul_v=%b div_v=%b busy=%b err=%b mul_a=%h div_a=%h, required rx_rdy=1 others 0",
               name, rx_ready_o, tx_valid_o, tx_data_o, mul_valid_o, div_valid_o, busy_o, err_o, mul_a_o, div_a_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("after_reset");
  endtask

  task automatic test_echo();
    pkt_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h42, 8'h69, 8'h42, 8'h69};
    run_packet("echo4");
    pkt_raw(ECHO, 4);
    run_packet("echo_empty");
  endtask

  task automatic test_mul();
    pkt_arith(MUL, 3, 32'd2, 32'd3, 32'd7, 32'd0);
    run_packet("mul_2_3_7");
    pkt_arith(MUL, 2, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0);
    run_packet("mul_neg");
  endtask

  task automatic test_div();
    pkt_arith(DIV, 2, 32'd100, 32'd7, 32'd0, 32'd0);
    run_packet("div_100_7");
    pkt_arith(DIV, 2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    run_packet("div_m7_2");
    pkt_arith(DIV, 2, 32'd55, 32'd0, 32'd0, 32'd0);
    run_packet("div_by_zero");
  endtask

  task automatic test_add_stall();
    int t, sz;
    pkt_arith(ADD, 2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    start_pkt(); send_all();
    t = 0;
    while (got_q.size() < 1 && t < 2000) begin @(negedge clk_i); t++; end
    stall = 1'b1;
    @(negedge clk_i);
    sz = got_q.size();
    repeat (20) @(negedge clk_i);
    checks++;
    if (got_q.size() !== sz || tx_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL add_stall: bytes %0d valid %b, required bytes %0d valid 1", got_q.size(), tx_valid_o, sz);
    end
    stall = 1'b0;
    finish_pkt("add_wrap_stall");
    pkt_arith(ADD, 4, 32'd10, 32'hFFFF_FFF0, 32'd1000, 32'h7FFF_FFFF);
    run_packet("add4");
  endtask

  task automatic test_malformed();
    pkt_raw(8'h55, 6);
    pkt_q.push_back(8'hEC); pkt_q.push_back(8'h00); pkt_q.push_back(8'h05);
    pkt_q.push_back(8'h00); pkt_q.push_back(8'h42);
    run_packet("bad_opc_then_echo");
    pkt_raw(ECHO, 2);
    run_packet("len_short");
    pkt_raw(ADD, 10);
    run_packet("add_len10");
    pkt_raw(DIV, 16);
    run_packet("div_len16");
    pkt_raw(MUL, 8);
    run_packet("mul_one_op");
    pkt_raw(ECHO, 1030);
    run_packet("len_over_max");
  endtask

  task automatic test_reset_mid();
    pkt_arith(MUL, 3, 32'd2, 32'd3, 32'd7, 32'd0);
    got_q.delete(); err_seen = 0; mul_hs = 0; div_hs = 0;
    for (int k = 0; k < 6; k++) send_byte(pkt_q[k]);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_packet busy: got %b, required 1", busy_o);
    end
    rst_i = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    repeat (5) @(negedge clk_i);
    rst_i = 1'b0;
    pkt_q.delete();
    repeat (5) @(negedge clk_i);
    checks++;
    if (got_q.size() !== 0 || mul_hs !== 0 || err_seen !== 0) begin
      errors++;
      $display("FAIL reset_quiet: tx %0d mul %0d err %0d, required 0 0 0", got_q.size(), mul_hs, err_seen);
    end
    pkt_arith(DIV, 2, 32'd9, 32'd3, 32'd0, 32'd0);
    run_packet("div_after_reset");
  endtask

  task automatic test_back_to_back();
    stray_en = 1'b1;
    pkt_raw(ECHO, 7);
    pkt_arith(MUL, 4, 32'd3, 32'hFFFF_FFFF, 32'd11, 32'd13);
    pkt_arith(ADD, 3, 32'd1, 32'd2, 32'd3, 32'd0);
    pkt_arith(DIV, 2, 32'd1000, 32'hFFFF_FFFD, 32'd0, 32'd0);
    run_packet("back_to_back");
  endtask

  task automatic test_random();
    int kind, n;
    logic [31:0] a, b;
    stray_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      kind = int'($urandom % 5);
      n = int'($urandom_range(2, 4));
      case (kind)
        0: pkt_raw(ECHO, 4 + int'($urandom % 7));
        1: pkt_arith(ADD, n, $urandom, $urandom, $urandom, $urandom);
        2: pkt_arith(MUL, n, $urandom, $urandom, $urandom, $urandom);
        3: begin
          a = $urandom;
          if (a == 32'h8000_0000) a = 32'd1;
          b = 32'($urandom_range(0, 20)) - 32'd10;
          pkt_arith(DIV, 2, a, b, 32'd0, 32'd0);
        end
        default: begin
          case ($urandom % 4)
            0: pkt_raw(8'($urandom_range(0, 127)), 4 + int'($urandom % 6));
            1: pkt_raw(ADD, 14);
            2: pkt_raw(DIV, 8);
            default: pkt_raw(MUL, 3);
          endcase
        end
      endcase
      run_packet($sformatf("rand%0d", p));
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_mul();
    test_div();
    test_add_stall();
    test_malformed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
